// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: load/store access controller for a 32-bit word RAM without byte enables.
// Sub-word stores are done as read-modify-write. Loads are lane-extracted and sign- or
// zero-extended. Misaligned or illegal accesses complete immediately with err_o and have
// no RAM effect. Only one request is in flight at a time.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i, we_i         request (sampled while ready_o), 1=store / 0=load
//   addr_i              byte address; word index = addr_i[AW+1:2]; upper bits wrap
//   size_i              00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i          load zero-extend (1) / sign-extend (0)
//   wdata_i             store data, right-aligned
//   ready_o             idle, request can be accepted
//   done_o, err_o       one-cycle completion pulse; err_o qualifies done_o
//   rdata_o             last load result, held until the next load completes
//   ram_r_*             RAM read port, data returns one cycle after ram_r_en_o
//   ram_w_*             RAM write port
module mem_rmw_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [31:0]   addr_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [31:0]   wdata_i,
  output logic          ready_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   rdata_o,
  output logic          ram_r_en_o,
  output logic [AW-1:0] ram_r_addr_o,
  input  logic [31:0]   ram_r_data_i,
  output logic          ram_w_en_o,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [31:0]   ram_w_data_o
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StMrg, StWr} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          misaligned;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [31:0]   merged;

  // Address bits above the RAM word index are intentionally ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  assign misaligned = (size_i == 2'b11) ||
                      ((size_i == SizeHalf) && addr_i[0]) ||
                      ((size_i == SizeWord) && (addr_i[1:0] != 2'b00));

  // Load lane extraction from the returned RAM word.
  always_comb begin
    ld_byte = 8'h00;
    unique case (off_q)
      2'd0: ld_byte = ram_r_data_i[7:0];
      2'd1: ld_byte = ram_r_data_i[15:8];
      2'd2: ld_byte = ram_r_data_i[23:16];
      2'd3: ld_byte = ram_r_data_i[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = off_q[1] ? ram_r_data_i[31:16] : ram_r_data_i[15:0];
    ld_val  = ram_r_data_i;
    if (size_q == SizeByte) begin
      ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
    end else if (size_q == SizeHalf) begin
      ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
    end
  end

  // Store merge: replace the addressed lane of the read word with the store data.
  always_comb begin
    merged = ram_r_data_i;
    if (size_q == SizeByte) begin
      unique case (off_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_r_data_i;
      endcase
    end else if (size_q == SizeHalf) begin
      if (off_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0] = wdata_q[15:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          off_d   = addr_i[1:0];
          waddr_d = addr_i[AW+1:2];
          wdata_d = wdata_i;
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (we_i && (size_i == SizeWord)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        state_d = StMrg;
      end
      StMrg: begin
        if (!we_q) begin
          rdata_d = ld_val;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StWr: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM controls decode from state and captured registers only.
  always_comb begin
    ready_o      = (state_q == StIdle);
    done_o       = done_q;
    err_o        = err_q;
    rdata_o      = rdata_q;
    ram_r_en_o   = (state_q == StRd);
    ram_r_addr_o = waddr_q;
    ram_w_en_o   = (state_q == StWr) || ((state_q == StMrg) && we_q);
    ram_w_addr_o = waddr_q;
    ram_w_data_o = (state_q == StMrg) ? merged : wdata_q;
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
module tb_mem_rmw_ctrl;
  localparam int unsigned AW    = 12;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [1:0]    size = 2'b00;
  logic          uns = 1'b0;
  logic [31:0]   wdata = 32'h0;
  logic          ready, done, err;
  logic [31:0]   rdata;
  logic          ram_r_en, ram_w_en;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic [31:0]   ram_r_data = 32'h0;
  logic [31:0]   ram_w_data;

  always #5 clk = ~clk;

  mem_rmw_ctrl #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .size_i       (size),
    .unsigned_i   (uns),
    .wdata_i      (wdata),
    .ready_o      (ready),
    .done_o       (done),
    .err_o        (err),
    .rdata_o      (rdata),
    .ram_r_en_o   (ram_r_en),
    .ram_r_addr_o (ram_r_addr),
    .ram_r_data_i (ram_r_data),
    .ram_w_en_o   (ram_w_en),
    .ram_w_addr_o (ram_w_addr),
    .ram_w_data_o (ram_w_data)
  );

  // Environment RAM (1-cycle read latency) and the reference memory image.
  logic [31:0] ram     [Depth] = '{default: 32'h0};
  logic [31:0] ref_mem [Depth] = '{default: 32'h0};
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0, idle_en_cnt = 0;

  always @(posedge clk) begin
    if (ram_w_en) begin
      ram[ram_w_addr] <= ram_w_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_r_en) begin
      ram_r_data <= ram[ram_r_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ram_r_en && ram_w_en) both_cnt <= both_cnt + 1;
    if (ready && (ram_r_en || ram_w_en)) idle_en_cnt <= idle_en_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: apply one access to ref_mem / exp_rdata; returns expected latency and traffic.
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       output int lat, output int nrd, output int nwr, output logic mis);
    int unsigned idx, sh;
    logic [31:0] word, mask, v;
    idx  = int'(a[AW+1:2]);
    sh   = 8 * int'(a[1:0]);
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    word = ref_mem[idx];
    if (mis) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (w && sz == 2'b10) begin
      lat = 2; nrd = 0; nwr = 1;
      ref_mem[idx] = wd;
    end else if (w) begin
      lat = 3; nrd = 1; nwr = 1;
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      lat = 3; nrd = 1; nwr = 0;
      v = (word >> sh) & mask;
      if (!u && sz != 2'b10) begin
        if ((sz == 2'b00 && v[7]) || (sz == 2'b01 && v[15])) v = v | ~mask;
      end
      exp_rdata = v;
    end
  endtask

  // Wait (bounded) for done after an accept edge; returns cycles to done, 99 on timeout.
  task automatic wait_done(input string tag, input logic mis, output int lat);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "/ready_busy"}, 32'(ready), 32'(mis));
      if (done) break;
    end
    if (!done) lat = 99;
    check({tag, "/err"}, 32'(err), 32'(mis));
  endtask

  // One isolated request; called just after a negedge.
  task automatic do_op(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    int lat, nrd, nwr, got, r0, w0, d0;
    logic mis;
    int unsigned idx;
    idx = int'(a[AW+1:2]);
    model(w, a, sz, u, wd, lat, nrd, nwr, mis);
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    req = 1'b1; we = w; addr = a; size = sz; uns = u; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(tag, mis, got);
    #1;
    check({tag, "/latency"}, 32'(got), 32'(lat));
    check({tag, "/reads"}, 32'(rd_cnt - r0), 32'(nrd));
    check({tag, "/writes"}, 32'(wr_cnt - w0), 32'(nwr));
    check({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "/rdata"}, rdata, exp_rdata);
    check({tag, "/mem"}, ram[idx], ref_mem[idx]);
  endtask

  initial begin
    int lat, nrd, nwr, got, w0, d0;
    logic mis;
    logic [31:0] r, a;
    logic [2:0] pick;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/ready", 32'(ready), 32'd1);
    check("rst/done", 32'(done), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    check("rst/rdata", rdata, 32'h0);
    check("rst/ram_en", {30'd0, ram_r_en, ram_w_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store then word load
    do_op("t1_sw", 1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF);
    check("t1_mem_const", ram[32'h100 >> 2], 32'hDEADBEEF);
    do_op("t1_lw", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    check("t1_rdata_const", rdata, 32'hDEADBEEF);

    // 2: byte store via RMW, then reload
    do_op("t2_sb", 1'b1, 32'h101, 2'b00, 1'b0, 32'hFFFF_FF55);
    check("t2_mem_const", ram[32'h100 >> 2], 32'hDEAD55EF);
    do_op("t2_lw", 1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    check("t2_rdata_const", rdata, 32'hDEAD55EF);

    // 3: sub-word loads
    do_op("t3_lb", 1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
    check("t3_lb_const", rdata, 32'hFFFFFFDE);
    do_op("t3_lbu", 1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
    check("t3_lbu_const", rdata, 32'h000000DE);
    do_op("t3_lh", 1'b0, 32'h102, 2'b01, 1'b0, 32'h0);
    check("t3_lh_const", rdata, 32'hFFFFDEAD);
    do_op("t3_lhu", 1'b0, 32'h100, 2'b01, 1'b1, 32'h0);
    check("t3_lhu_const", rdata, 32'h000055EF);

    // 4: misaligned / illegal
    do_op("t4_lw_mis", 1'b0, 32'h102, 2'b10, 1'b0, 32'h0);
    do_op("t4_sh_mis", 1'b1, 32'h103, 2'b01, 1'b0, 32'h1234);
    do_op("t4_ill", 1'b1, 32'h100, 2'b11, 1'b0, 32'h0);
    check("t4_mem_const", ram[32'h100 >> 2], 32'hDEAD55EF);
    check("t4_rdata_const", rdata, 32'h000055EF);

    // 5: back-to-back byte stores with req held high
    do_op("t5_pre", 1'b1, 32'h200, 2'b10, 1'b0, 32'hA5000000);
    bb_addr[0] = 32'h200; bb_addr[1] = 32'h201; bb_addr[2] = 32'h202;
    bb_data[0] = 32'h11;  bb_data[1] = 32'h22;  bb_data[2] = 32'h33;
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0;
    addr = bb_addr[0]; wdata = bb_data[0];
    for (int k = 0; k < 3; k++) begin
      model(1'b1, bb_addr[k], 2'b00, 1'b0, bb_data[k], lat, nrd, nwr, mis);
      @(posedge clk);
      wait_done("t5_b2b", 1'b0, got);
      check("t5_latency", 32'(got), 32'(lat));
      check("t5_ready_in_done", 32'(ready), 32'd1);
      if (k < 2) begin
        addr = bb_addr[k+1]; wdata = bb_data[k+1];
      end else begin
        req = 1'b0;
      end
    end
    #1;
    check("t5_mem", ram[32'h200 >> 2], ref_mem[32'h200 >> 2]);
    check("t5_mem_const", ram[32'h200 >> 2], 32'hA5332211);

    // 6: reset during MRG of a sub-word store
    do_op("t6_pre", 1'b1, 32'h104, 2'b10, 1'b0, 32'h12345678);
    w0 = wr_cnt; d0 = done_cnt;
    req = 1'b1; we = 1'b1; addr = 32'h104; size = 2'b00; uns = 1'b0; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_wen_in_mrg", 32'(ram_w_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_wen_after_rst", 32'(ram_w_en), 32'd0);
    check("t6_ready_in_rst", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    exp_rdata = 32'h0;
    check("t6_writes", 32'(wr_cnt - w0), 32'd0);
    check("t6_done", 32'(done_cnt - d0), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_mem", ram[32'h104 >> 2], 32'h12345678);
    check("t6_rdata", rdata, exp_rdata);

    // Random mix in a small window, with random upper address bits for wrap.
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      a = (r & 32'hFFFF_C003) | 32'h300 | (32'($urandom_range(0, 7)) << 2);
      pick = 3'($urandom_range(0, 7));
      do_op("rand", 1'($urandom_range(0, 1)), a,
            (pick < 3) ? 2'b00 : (pick < 5) ? 2'b01 : (pick < 7) ? 2'b10 : 2'b11,
            1'($urandom_range(0, 1)), $urandom());
    end

    check("overlap_r_w_en", 32'(both_cnt), 32'd0);
    check("idle_ram_en", 32'(idle_en_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
